hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the combinational hazard unit. It tracks every in-flight register write in a shift-register scoreboard spanning DEPTH back-end stages and counts down each producer's result latency stage by stage. It resolves per-operand forwarding selects and decode stalls for NSRC source operands, and optionally tracks a multi-cycle multiply/divide unit. It sits beside the decode stage and drives the D-stage operand muxes plus the D/E stall and bubble controls.

## Interface
- NSRC, 2: source operands checked per decoded instruction
- DEPTH, 3: tracked stages after decode (stage 0 = E, DEPTH-1 = W)
- LATW, 2: width of per-entry latency field
- MDU_LAT, 32: busy cycles loaded on an MDU start
- SELW, $clog2(DEPTH+1): width of one forwarding select
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  valid instruction in D
- id_src  in  NSRC*5  source register numbers, operand k at [5k+4:5k]
- id_src_used  in  NSRC  operand k is actually read
- id_wen  in  1  D instruction writes a GPR
- id_dst  in  5  destination register
- id_lat  in  LATW  stages after E entry before the result is forwardable (ALU 1, load 2)
- id_hilo_rd  in  1  D instruction reads HI/LO
- mdu_start  in  1  MDU operation launched in E (pulse)
- pipe_stall  in  1  back-end freeze (cache/bus wait)
- flush  in  1  exception flush
- fwd_sel  out  NSRC*SELW  per operand: 0 = regfile, i+1 = result of stage i
- stall_d  out  1  hold F and D
- bubble_e  out  1  insert a bubble into E
- mdu_busy  out  1  MDU counter non-zero

## Operation
- Entry i holds {v, dst[4:0], rem[LATW-1:0]}.
- issue = id_valid & ~stall_d & ~flush & ~pipe_stall.
- Advance when ~pipe_stall:
  - entry[i+1] <= entry[i], with rem decremented and saturating at 0.
  - entry[0] <= {issue & id_wen & (id_dst != 0), id_dst, id_lat}.
  - entry[DEPTH-1] retires.
- When pipe_stall: all entries hold, including rem.
- flush: all v cleared on the next edge. This overrides the advance.
- Operand k match: id_src_used[k], src != 0, v, dst == src.
  - The youngest match (lowest i) decides.
  - rem == 0 gives fwd_sel = i+1.
  - rem != 0 gives an operand stall and fwd_sel = 0.
  - No match gives fwd_sel = 0.
- stall_d = id_valid & ~flush & (any operand stall | (id_hilo_rd & (mdu_busy | mdu_start))).
- bubble_e = stall_d & ~pipe_stall.
- fwd_sel, stall_d and bubble_e are combinational from the registered state and the D inputs.
- MDU counter:
  - mdu_start loads MDU_LAT, or reloads it if already busy.
  - Otherwise the counter decrements each cycle while non-zero, independent of pipe_stall and flush, because the divider cannot abort.

## Timing
- Reset values: all v = 0, MDU counter 0, mdu_busy 0, fwd_sel 0, stall_d 0, bubble_e 0.
- Reset asserted mid-operation clears state immediately.
- A producer with id_lat = L issued in cycle t is forwardable from cycle t+L+1.
  - Dependents in cycles t+1..t+L stall.
  - From cycle t+L+1 the dependent sees fwd_sel = L+1, while the producer is in stage L.
- A producer that stays in the window past stage L keeps forwarding from its current stage.
- Once the producer retires from stage DEPTH-1, fwd_sel = 0 (write-before-read regfile).
- mdu_busy is high for exactly MDU_LAT cycles after the mdu_start edge.

## Configuration
- HAZARD_MDU_EN defined: MDU counter, mdu_busy and the HI/LO stall term are present.
- HAZARD_MDU_EN undefined:
  - mdu_start and id_hilo_rd are ignored.
  - mdu_busy is tied to 0.
  - The HI/LO stall term is 0 (the MDU is single-cycle or absent).

## Test plan
All scenarios use DEPTH=3 and MDU_LAT=4.

- ALU chain: issue r3 with lat 1, then next D reads r3 on operand 0 -> one cycle stall_d=1 and bubble_e=1, then fwd_sel[0]=2.
- Load-use: issue load r5 with lat 2, then dependent on operand 1 -> two stall cycles, then fwd_sel[1]=3; a third dependent one cycle later -> fwd_sel=0.
- Youngest wins: r4 written by two in-flight entries at stages 2 and 1 (rem 0) -> fwd_sel=2; r0 source with a matching r0 dst -> never stall, sel 0.
- pipe_stall: assert for 3 cycles with a pending lat-2 entry -> entries and rem frozen, stall_d held, bubble_e=0; resume -> same forwarding as without the freeze.
- flush: assert with 3 valid entries -> next cycle all v=0 and a dependent reads fwd_sel=0 with no stall; the MDU counter is unaffected.
- MDU (HAZARD_MDU_EN): mdu_start with mfhi in D the same cycle -> stall for that cycle plus 4 busy cycles; second mdu_start at busy cycle 2 -> busy extends to 4 cycles from the reload.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hazard_scoreboard_if
// Purpose  : D-stage decode and back-end control bundle for the hazard scoreboard
// Revision : 1.0
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int LATW  = 2,
  parameter int SELW  = $clog2(DEPTH + 1)
);
  logic                   id_valid;
  logic [NSRC*5-1:0]      id_src;
  logic [NSRC-1:0]        id_src_used;
  logic                   id_wen;
  logic [4:0]             id_dst;
  logic [LATW-1:0]        id_lat;
  logic                   id_hilo_rd;
  logic                   mdu_start;
  logic                   pipe_stall;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall_d;
  logic                   bubble_e;
  logic                   mdu_busy;

  modport master (
    output id_valid, id_src, id_src_used, id_wen, id_dst, id_lat,
           id_hilo_rd, mdu_start, pipe_stall, flush,
    input  fwd_sel, stall_d, bubble_e, mdu_busy
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_wen, id_dst, id_lat,
           id_hilo_rd, mdu_start, pipe_stall, flush,
    output fwd_sel, stall_d, bubble_e, mdu_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hazard_scoreboard
// Purpose  : shift-register scoreboard resolving forwarding selects and decode
//            stalls; the multi-cycle MDU tracker is enabled by HAZARD_MDU_EN
// Revision : 1.0
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NSRC    = 2,
  parameter int DEPTH   = 3,
  parameter int LATW    = 2,
  parameter int MDU_LAT = 32,
  parameter int SELW    = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hazard_scoreboard_if.slave sb
);
  localparam int CNTW = $clog2(MDU_LAT + 1);

  logic [DEPTH-1:0]     v_q, v_d;
  logic [4:0]           dst_q [DEPTH];
  logic [4:0]           dst_d [DEPTH];
  logic [LATW-1:0]      rem_q [DEPTH];
  logic [LATW-1:0]      rem_d [DEPTH];
  logic                 issue;
  logic                 stall_d;
  logic                 hilo_stall;
  logic                 mdu_busy;
  logic [NSRC-1:0]      src_stall;
  logic [NSRC*SELW-1:0] fwd_sel;

  assign issue = sb.id_valid & ~stall_d & ~sb.flush & ~sb.pipe_stall;

  always_comb begin
    v_d   = v_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (!sb.pipe_stall) begin
      v_d[0]   = issue & sb.id_wen & (sb.id_dst != 5'd0);
      dst_d[0] = sb.id_dst;
      rem_d[0] = sb.id_lat;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]   = v_q[i-1];
        dst_d[i] = dst_q[i-1];
        rem_d[i] = (rem_q[i-1] != '0) ? rem_q[i-1] - LATW'(1) : '0;
      end
    end
    // A flush kills every in-flight write regardless of the freeze.
    if (sb.flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  // Scan oldest to youngest so the lowest matching stage has the final say.
  always_comb begin
    fwd_sel   = '0;
    src_stall = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (sb.id_src_used[k] && (sb.id_src[5*k +: 5] != 5'd0) &&
            v_q[i] && (dst_q[i] == sb.id_src[5*k +: 5])) begin
          if (rem_q[i] == '0) begin
            fwd_sel[SELW*k +: SELW] = SELW'(i + 1);
            src_stall[k]            = 1'b0;
          end else begin
            fwd_sel[SELW*k +: SELW] = '0;
            src_stall[k]            = 1'b1;
          end
        end
      end
    end
  end

`ifdef HAZARD_MDU_EN
  logic [CNTW-1:0] mdu_cnt_q, mdu_cnt_d;

  // The divider cannot abort, so neither freeze nor flush touches the counter.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (sb.mdu_start) begin
      mdu_cnt_d = CNTW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt_q <= '0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign mdu_busy   = (mdu_cnt_q != '0);
  assign hilo_stall = sb.id_hilo_rd & (mdu_busy | sb.mdu_start);
`else
  logic unused_mdu;
  assign unused_mdu = ^{sb.mdu_start, sb.id_hilo_rd, CNTW'(MDU_LAT)};
  assign mdu_busy   = 1'b0;
  assign hilo_stall = 1'b0;
`endif

  assign stall_d     = sb.id_valid & ~sb.flush & ((|src_stall) | hilo_stall);
  assign sb.stall_d  = stall_d;
  assign sb.bubble_e = stall_d & ~sb.pipe_stall;
  assign sb.fwd_sel  = fwd_sel;
  assign sb.mdu_busy = mdu_busy;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_hazard_scoreboard
// Purpose  : directed bench for hazard_scoreboard (DEPTH=3, MDU_LAT=4)
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_scoreboard_if #(.NSRC(2), .DEPTH(3), .LATW(2)) bus ();

  hazard_scoreboard #(
    .NSRC(2), .DEPTH(3), .LATW(2), .MDU_LAT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid    = 1'b0;
    bus.id_src      = '0;
    bus.id_src_used = '0;
    bus.id_wen      = 1'b0;
    bus.id_dst      = '0;
    bus.id_lat      = '0;
    bus.id_hilo_rd  = 1'b0;
    bus.mdu_start   = 1'b0;
    bus.pipe_stall  = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic wen, input logic [4:0] dst,
                       input logic [1:0] lat);
    bus.id_valid    = v;
    bus.id_src      = {s1, s0};
    bus.id_src_used = used;
    bus.id_wen      = wen;
    bus.id_dst      = dst;
    bus.id_lat      = lat;
    #2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_fwd_sel", bus.fwd_sel, 0);
    check("rst_stall_d", bus.stall_d, 0);
    check("rst_bubble_e", bus.bubble_e, 0);
    check("rst_mdu_busy", bus.mdu_busy, 0);
    rst = 1'b0;
    cyc();

    // ALU chain: r3 lat 1, dependent on operand 0
    drive(1, 0, 0, 2'b00, 1, 5'd3, 2'd1);
    check("alu_prod_stall", bus.stall_d, 0);
    cyc();
    drive(1, 5'd3, 0, 2'b01, 0, 0, 0);
    check("alu_dep_stall", bus.stall_d, 1);
    check("alu_dep_bubble", bus.bubble_e, 1);
    check("alu_dep_sel_wait", bus.fwd_sel, 0);
    cyc();
    drive(1, 5'd3, 0, 2'b01, 0, 0, 0);
    check("alu_dep_go", bus.stall_d, 0);
    check("alu_dep_sel", bus.fwd_sel[1:0], 2);
    cyc();
    idle();
    repeat (3) cyc();

    // Load-use: r5 lat 2, dependent on operand 1
    drive(1, 0, 0, 2'b00, 1, 5'd5, 2'd2);
    cyc();
    drive(1, 0, 5'd5, 2'b10, 0, 0, 0);
    check("ld_stall1", bus.stall_d, 1);
    cyc();
    drive(1, 0, 5'd5, 2'b10, 0, 0, 0);
    check("ld_stall2", bus.stall_d, 1);
    check("ld_bubble2", bus.bubble_e, 1);
    cyc();
    drive(1, 0, 5'd5, 2'b10, 0, 0, 0);
    check("ld_go", bus.stall_d, 0);
    check("ld_sel1", bus.fwd_sel[3:2], 3);
    cyc();
    drive(1, 0, 5'd5, 2'b10, 0, 0, 0);
    check("ld_retired_sel", bus.fwd_sel, 0);
    check("ld_retired_stall", bus.stall_d, 0);
    cyc();
    idle();
    repeat (3) cyc();

    // Youngest wins: r4 at stages 2 and 1, both rem 0; r0 never matches
    drive(1, 0, 0, 2'b00, 1, 5'd4, 2'd1);
    cyc();
    drive(1, 0, 0, 2'b00, 1, 5'd4, 2'd1);
    cyc();
    idle();
    cyc();
    drive(1, 5'd4, 5'd0, 2'b11, 1, 5'd0, 2'd2);
    check("young_sel0", bus.fwd_sel[1:0], 2);
    check("young_sel1_r0", bus.fwd_sel[3:2], 0);
    check("young_stall", bus.stall_d, 0);
    cyc();
    drive(1, 5'd0, 5'd0, 2'b11, 0, 0, 0);
    check("r0_stall", bus.stall_d, 0);
    check("r0_sel", bus.fwd_sel, 0);
    cyc();
    idle();
    repeat (3) cyc();

    // pipe_stall freezes a pending lat-2 entry for three cycles
    drive(1, 0, 0, 2'b00, 1, 5'd6, 2'd2);
    cyc();
    bus.pipe_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(1, 5'd6, 0, 2'b01, 0, 0, 0);
      check("frz_stall", bus.stall_d, 1);
      check("frz_bubble", bus.bubble_e, 0);
      cyc();
    end
    bus.pipe_stall = 1'b0;
    drive(1, 5'd6, 0, 2'b01, 0, 0, 0);
    check("frz_res_stall1", bus.stall_d, 1);
    check("frz_res_bubble1", bus.bubble_e, 1);
    cyc();
    drive(1, 5'd6, 0, 2'b01, 0, 0, 0);
    check("frz_res_stall2", bus.stall_d, 1);
    cyc();
    drive(1, 5'd6, 0, 2'b01, 0, 0, 0);
    check("frz_res_go", bus.stall_d, 0);
    check("frz_res_sel", bus.fwd_sel[1:0], 3);
    cyc();
    idle();
    repeat (3) cyc();

    // flush with three valid entries; an MDU op is launched alongside
    bus.mdu_start = 1'b1;
    drive(1, 0, 0, 2'b00, 1, 5'd7, 2'd1);
    cyc();
    bus.mdu_start = 1'b0;
    drive(1, 0, 0, 2'b00, 1, 5'd8, 2'd1);
    cyc();
    drive(1, 0, 0, 2'b00, 1, 5'd9, 2'd2);
    cyc();
    bus.flush = 1'b1;
    drive(1, 5'd9, 5'd8, 2'b11, 0, 0, 0);
    check("flush_now_stall", bus.stall_d, 0);
    check("flush_now_bubble", bus.bubble_e, 0);
    cyc();
    bus.flush = 1'b0;
    drive(1, 5'd9, 5'd8, 2'b11, 0, 0, 0);
    check("flush_after_stall", bus.stall_d, 0);
    check("flush_after_sel", bus.fwd_sel, 0);
`ifdef HAZARD_MDU_EN
    check("flush_mdu_busy", bus.mdu_busy, 1);
`endif
    cyc();
`ifdef HAZARD_MDU_EN
    check("flush_mdu_done", bus.mdu_busy, 0);
`endif
    idle();
    repeat (2) cyc();

`ifdef HAZARD_MDU_EN
    // mfhi in D together with mdu_start
    bus.mdu_start  = 1'b1;
    bus.id_hilo_rd = 1'b1;
    drive(1, 0, 0, 2'b00, 1, 5'd10, 2'd1);
    check("mdu_start_stall", bus.stall_d, 1);
    check("mdu_start_busy", bus.mdu_busy, 0);
    cyc();
    bus.mdu_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      drive(1, 0, 0, 2'b00, 1, 5'd10, 2'd1);
      check("mdu_busy_n", bus.mdu_busy, 1);
      check("mdu_hilo_stall", bus.stall_d, 1);
      cyc();
    end
    drive(1, 0, 0, 2'b00, 1, 5'd10, 2'd1);
    check("mdu_idle_busy", bus.mdu_busy, 0);
    check("mdu_idle_stall", bus.stall_d, 0);
    cyc();
    idle();
    cyc();
    // reload at busy cycle 2
    bus.mdu_start = 1'b1;
    #2;
    cyc();
    bus.mdu_start = 1'b0;
    #2;
    check("mdu_rl_b1", bus.mdu_busy, 1);
    cyc();
    bus.mdu_start = 1'b1;
    #2;
    check("mdu_rl_b2", bus.mdu_busy, 1);
    cyc();
    bus.mdu_start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #2;
      check("mdu_rl_ext", bus.mdu_busy, 1);
      cyc();
    end
    #2;
    check("mdu_rl_end", bus.mdu_busy, 0);
    cyc();
`else
    bus.mdu_start  = 1'b1;
    bus.id_hilo_rd = 1'b1;
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    check("nomdu_stall", bus.stall_d, 0);
    cyc();
    bus.mdu_start = 1'b0;
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    check("nomdu_busy", bus.mdu_busy, 0);
    check("nomdu_stall2", bus.stall_d, 0);
    cyc();
`endif
    idle();
    cyc();

    // asynchronous reset mid-operation
    drive(1, 0, 0, 2'b00, 1, 5'd11, 2'd2);
    cyc();
    drive(1, 5'd11, 0, 2'b01, 0, 0, 0);
    check("arst_pre_stall", bus.stall_d, 1);
    rst = 1'b1;
    #1;
    check("arst_stall", bus.stall_d, 0);
    check("arst_bubble", bus.bubble_e, 0);
    check("arst_sel", bus.fwd_sel, 0);
    cyc();
    rst = 1'b0;
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
